prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: instruction byte width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: memory address width, giving 16 locations.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port load_en  in  1: host requests or holds load mode.
REQ-006 SHALL have port wr_valid  in  1: host byte valid.
REQ-007 SHALL have port wr_data  in  DATA_WIDTH: host instruction byte.
REQ-008 SHALL have port wr_ready  out  1: loader accepts a byte this cycle.
REQ-009 SHALL have port chk_in  in  DATA_WIDTH: expected modulo-256 sum of the loaded bytes.
REQ-010 SHALL have port fetch_addr  in  ADDR_WIDTH: CPU program counter.
REQ-011 SHALL have port fetch_data  out  DATA_WIDTH: instruction byte at fetch_addr.
REQ-012 SHALL have port cpu_rst_n  out  1: active-low reset to the downstream CPU.
REQ-013 SHALL have port byte_count  out  ADDR_WIDTH+1: bytes accepted in the current load, range 0..16.
REQ-014 SHALL have port checksum  out  DATA_WIDTH: running sum of accepted bytes.
REQ-015 SHALL have port status  out  3: current state encoding.

Function
REQ-016 SHALL hold a 16x8 memory; fetch_data SHALL be a combinational read of mem[fetch_addr] in every state.
REQ-017 SHALL implement states IDLE=0, LOAD=1, FILL=2, CHECK=3, READY=4, ERROR=5; status SHALL equal the state.
REQ-018 IDLE: if load_en=1, go to LOAD next cycle, clearing write address, byte_count and checksum.
REQ-019 LOAD: wr_ready=1 only in LOAD and only while byte_count<16.
REQ-020 A transfer occurs when wr_valid=1 and wr_ready=1.
- Each transfer writes mem[addr]=wr_data.
- Each transfer increments addr by 1 and byte_count by 1.
- Each transfer adds wr_data to checksum, modulo 256, carry discarded.
REQ-021 LOAD exit on a 16th transfer: go directly to CHECK the following cycle.
REQ-022 LOAD exit with load_en=0 and byte_count<16: go to FILL.
REQ-023 If load_en falls in the same cycle as a valid transfer, the byte SHALL be accepted first, then the exit of REQ-021/REQ-022 applies.
REQ-024 FILL: write 8'hFF (the CPU HALT encoding) to mem[addr] one location per cycle, incrementing addr.
- After writing location 15, go to CHECK.
- byte_count and checksum SHALL NOT change in FILL.
REQ-025 CHECK: lasts exactly one cycle; chk_in is sampled in this cycle.
- If checksum==chk_in, go to READY.
- Otherwise go to ERROR.
REQ-026 cpu_rst_n SHALL be 1 only in READY and 0 in every other state.
- It SHALL be driven from the registered state, with no combinational path from inputs.
REQ-027 READY or ERROR: load_en=1 SHALL start a new load exactly as in REQ-018; cpu_rst_n falls the same cycle the state leaves READY.
REQ-028 An empty load (load_en dropped with byte_count=0) SHALL fill all 16 locations with 8'hFF, then compare checksum 0 against chk_in.
REQ-029 The write address SHALL wrap 15->0 without affecting byte_count; FILL never runs when byte_count=16.
REQ-030 wr_valid outside LOAD SHALL be ignored, with no memory write and no counter change.

Reset
REQ-031 While rst_n=0, asynchronously:
- state=IDLE.
- addr=0, byte_count=0, checksum=8'h00.
- all 16 memory locations=8'hFF.
- wr_ready=0 and cpu_rst_n=0.
REQ-032 Reset asserted mid-LOAD or mid-FILL SHALL abandon the load, with every register set per REQ-031.
REQ-033 After rst_n rises, the first state change SHALL occur on the next clk edge with load_en=1.

Verification
REQ-034 Full load: load 16 bytes 0x01..0x10 back-to-back, chk_in=0x88.
- Expected: CHECK then READY.
- Expected: cpu_rst_n=1, byte_count=16, fetch_data at addr 5 = 0x06.
REQ-035 Partial load: load 0x88, 0x91, drop load_en, chk_in=0x19.
- Expected: 14 FILL cycles, then READY.
- Expected: mem[2..15]=0xFF, checksum=0x19.
REQ-036 Checksum mismatch: same as REQ-034 with chk_in=0x00.
- Expected: ERROR, cpu_rst_n stays 0.
- Expected: reasserting load_en enters LOAD with checksum=0.
REQ-037 Backpressure and simultaneous exit: toggle wr_valid; drop load_en in the same cycle as the 3rd transfer.
- Expected: exactly 3 bytes written, byte_count=3, then FILL.
REQ-038 Reset mid-load: assert rst_n=0 after 7 bytes.
- Expected: immediately status=0, byte_count=0, all fetch_data=0xFF, cpu_rst_n=0.
REQ-039 Reload from READY: assert load_en.
- Expected: cpu_rst_n=0 on the next edge; wr_valid pulses in READY/ERROR do not alter memory.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: host streams instruction bytes into a small memory,
// pads unused locations with HALT, verifies a checksum, releases the CPU.
module prog_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] chk_in,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  cpu_rst_n,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [2:0]            status
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [DATA_WIDTH-1:0] HALT = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FILL  = 3'd2,
    S_CHECK = 3'd3,
    S_READY = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic                  xfer;
  logic                  we;
  logic [DATA_WIDTH-1:0] wd;

  // Registered state, counters and program memory; reset wipes memory to HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= HALT;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_READY, S_ERROR: begin
        if (load_en) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (xfer && (cnt_q == FULL - CW'(1))) begin
          state_d = S_CHECK;
        end else if (!load_en) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (addr_q == LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = (sum_q == chk_in) ? S_READY : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: address/count/checksum updates and the single memory write port
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    we     = 1'b0;
    wd     = HALT;
    unique case (state_q)
      S_IDLE, S_READY, S_ERROR: begin
        if (load_en) begin
          addr_d = '0;
          cnt_d  = '0;
          sum_d  = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we     = 1'b1;
          wd     = wr_data;
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q + CW'(1);
          sum_d  = sum_q + wr_data;
        end
      end
      S_FILL: begin
        we     = 1'b1;
        wd     = HALT;
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // Memory next value from the write port
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) mem_d[addr_q] = wd;
  end

  // Outputs decoded from registered state only
  always_comb begin
    wr_ready  = (state_q == S_LOAD) && (cnt_q < FULL);
    cpu_rst_n = (state_q == S_READY);
    xfer      = wr_valid && wr_ready;
  end

  assign fetch_data = mem_q[fetch_addr];
  assign byte_count = cnt_q;
  assign checksum   = sum_q;
  assign status     = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: full, partial, empty, mismatch,
// backpressure and reset-abandon scenarios with hand-computed values.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [7:0] chk_in;
  logic [3:0] fetch_addr;
  logic [7:0] fetch_data;
  logic       cpu_rst_n;
  logic [4:0] byte_count;
  logic [7:0] checksum;
  logic [2:0] status;

  int n_chk  = 0;
  int n_pass = 0;

  prog_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .chk_in    (chk_in),
    .fetch_addr(fetch_addr),
    .fetch_data(fetch_data),
    .cpu_rst_n (cpu_rst_n),
    .byte_count(byte_count),
    .checksum  (checksum),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    fetch_addr = a;
    #0.1;
    d = fetch_data;
  endtask

  // Streams 0x01..0x10 and stops at the CHECK cycle
  task automatic full_load(input logic [7:0] ck);
    chk_in  = ck;
    load_en = 1'b1;
    tick();
    check("load_entry", status, 1);
    check("load_ready", wr_ready, 1);
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i + 1);
      tick();
    end
    wr_valid = 1'b0;
    load_en  = 1'b0;
    check("full_check_st", status, 3);
    check("full_cnt", byte_count, 16);
    check("full_sum", checksum, 8'h88);
    check("full_ready0", wr_ready, 0);
  endtask

  // Counts cycles spent in FILL, bounded
  task automatic count_fill(output int n);
    n = 0;
    while (status == 3'd2 && n < 40) begin
      n++;
      tick();
    end
  endtask

  logic [7:0] d;
  int         n;
  int         bad;

  initial begin
    rst_n      = 1'b0;
    load_en    = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 8'h00;
    chk_in     = 8'h00;
    fetch_addr = 4'd0;
    tick();
    check("rst_status", status, 0);
    check("rst_cpu", cpu_rst_n, 0);
    check("rst_ready", wr_ready, 0);
    check("rst_cnt", byte_count, 0);
    check("rst_sum", checksum, 0);
    rd(4'd7, d);
    check("rst_mem", d, 8'hFF);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_hold", status, 0);

    // Full load, good checksum
    full_load(8'h88);
    tick();
    check("full_ready_st", status, 4);
    check("full_cpu", cpu_rst_n, 1);
    rd(4'd5, d);
    check("full_mem5", d, 8'h06);
    rd(4'd15, d);
    check("full_mem15", d, 8'h10);

    // Stray bytes in READY are ignored
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    tick();
    wr_valid = 1'b0;
    rd(4'd0, d);
    check("ready_nowr", d, 8'h01);
    check("ready_cnt", byte_count, 16);

    // Reload from READY; partial load 0x88, 0x91
    load_en = 1'b1;
    chk_in  = 8'h19;
    tick();
    check("reload_st", status, 1);
    check("reload_cpu", cpu_rst_n, 0);
    check("reload_sum", checksum, 0);
    check("reload_cnt", byte_count, 0);
    wr_valid = 1'b1;
    wr_data  = 8'h88;
    tick();
    wr_data  = 8'h91;
    tick();
    wr_valid = 1'b0;
    load_en  = 1'b0;
    tick();
    check("part_fill_st", status, 2);
    check("part_cnt", byte_count, 2);
    check("part_sum", checksum, 8'h19);
    count_fill(n);
    check("part_fill_n", n, 14);
    check("part_check_st", status, 3);
    check("part_fill_sum", checksum, 8'h19);
    tick();
    check("part_ready", status, 4);
    check("part_cpu", cpu_rst_n, 1);
    rd(4'd0, d);
    check("part_mem0", d, 8'h88);
    rd(4'd1, d);
    check("part_mem1", d, 8'h91);
    bad = 0;
    for (int a = 2; a < 16; a++) begin
      rd(4'(a), d);
      if (d !== 8'hFF) bad++;
    end
    check("part_pad", bad, 0);

    // Full load with wrong checksum
    full_load(8'h00);
    tick();
    check("mis_err_st", status, 5);
    check("mis_cpu", cpu_rst_n, 0);
    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    tick();
    tick();
    wr_valid = 1'b0;
    check("err_hold", status, 5);
    check("err_cnt", byte_count, 16);
    rd(4'd3, d);
    check("err_nowr", d, 8'h04);
    load_en = 1'b1;
    tick();
    check("err_reload", status, 1);
    check("err_resum", checksum, 0);

    // Backpressure; load_en drops with the 3rd transfer
    chk_in   = 8'h60;
    wr_valid = 1'b1;
    wr_data  = 8'h10;
    tick();
    wr_valid = 1'b0;
    tick();
    wr_valid = 1'b1;
    wr_data  = 8'h20;
    tick();
    wr_valid = 1'b0;
    tick();
    check("bp_cnt2", byte_count, 2);
    wr_valid = 1'b1;
    wr_data  = 8'h30;
    load_en  = 1'b0;
    tick();
    wr_valid = 1'b0;
    check("bp_fill_st", status, 2);
    check("bp_cnt", byte_count, 3);
    check("bp_sum", checksum, 8'h60);
    count_fill(n);
    check("bp_fill_n", n, 13);
    tick();
    check("bp_ready", status, 4);
    rd(4'd2, d);
    check("bp_mem2", d, 8'h30);
    rd(4'd3, d);
    check("bp_mem3", d, 8'hFF);

    // Reset after 7 bytes abandons the load
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h40 + i);
      tick();
    end
    wr_valid = 1'b0;
    check("mid_cnt", byte_count, 7);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_st", status, 0);
    check("arst_cnt", byte_count, 0);
    check("arst_cpu", cpu_rst_n, 0);
    check("arst_ready", wr_ready, 0);
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d);
      if (d !== 8'hFF) bad++;
    end
    check("arst_mem", bad, 0);
    load_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle", status, 0);

    // Empty load: pad everything, checksum 0
    chk_in  = 8'h00;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    tick();
    check("empty_fill_st", status, 2);
    count_fill(n);
    check("empty_fill_n", n, 16);
    tick();
    check("empty_ready", status, 4);
    check("empty_sum", checksum, 0);
    check("empty_cnt", byte_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
